// File: rtl/ir_pkg.sv
// Shared constants and field-width helpers for the instruction prefetch register.
// Format bit sits at the MSB; long/short formats differ in opcode and immediate width.
package ir_pkg;

  localparam int OPC_W = 5;

  localparam logic FMT_LONG  = 1'b1;
  localparam logic FMT_SHORT = 1'b0;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_t;

  function automatic int fmt_bit(input int inst_w);
    return inst_w - 1;
  endfunction

  function automatic int long_imm_w(input int inst_w);
    return inst_w - 3;
  endfunction

  function automatic int short_imm_w(input int inst_w);
    return inst_w - 5;
  endfunction

endpackage

// File: rtl/instr_prefetch_reg_if.sv
// Fetch-side and decode-side signals of the prefetch register.
// Handshake: a word moves on a rising edge when valid and ready are both high.
interface instr_prefetch_reg_if #(
  parameter int INST_W = 16,
  parameter int DEPTH  = 2
);
  import ir_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [INST_W-1:0] in_inst;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] out_inst;
  logic              out_long;
  logic [OPC_W-1:0]  out_opcode;
  logic [INST_W-1:0] out_imm;
  logic [CW-1:0]     count;

  modport slave (
    input  in_valid, in_inst, flush, out_ready,
    output in_ready, out_valid, out_inst, out_long, out_opcode, out_imm, count
  );

  modport master (
    output in_valid, in_inst, flush, out_ready,
    input  in_ready, out_valid, out_inst, out_long, out_opcode, out_imm, count
  );

endinterface

// File: rtl/ir_decode.sv
// Combinational split of an instruction word into format, opcode and extended immediate.
module ir_decode
  import ir_pkg::*;
#(
  parameter int INST_W   = 16,
  parameter int SIGN_EXT = 0
) (
  input  logic [INST_W-1:0] inst,
  output logic              long_fmt,
  output logic [OPC_W-1:0]  opcode,
  output logic [INST_W-1:0] imm
);

  localparam int FB = fmt_bit(INST_W);
  localparam int LW = long_imm_w(INST_W);
  localparam int SW = short_imm_w(INST_W);

  logic              ext_l;
  logic              ext_s;
  logic [INST_W-1:0] imm_long;
  logic [INST_W-1:0] imm_short;

  assign long_fmt = (inst[FB] == FMT_LONG);

  // Long opcodes carry only three bits; the two LSBs are padded with zero.
  assign opcode = long_fmt ? {inst[FB -: 3], 2'b00} : inst[FB -: OPC_W];

  assign ext_l     = (SIGN_EXT != 0) && inst[LW-1];
  assign ext_s     = (SIGN_EXT != 0) && inst[SW-1];
  assign imm_long  = {{(INST_W-LW){ext_l}}, inst[LW-1:0]};
  assign imm_short = {{(INST_W-SW){ext_s}}, inst[SW-1:0]};

  assign imm = long_fmt ? imm_long : imm_short;

endmodule

// File: rtl/instr_prefetch_reg.sv
// Small prefetch queue between instruction memory and the control unit.
// Handshake flags come from registered occupancy state only; flush wins over push/pop.
module instr_prefetch_reg
  import ir_pkg::*;
#(
  parameter int INST_W   = 16,
  parameter int DEPTH    = 2,
  parameter int SIGN_EXT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_prefetch_reg_if.slave  bus,
  output occ_state_t           dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [INST_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  occ_state_t        state_q;
  occ_state_t        state_d;

  logic              push;
  logic              pop;
  logic [INST_W-1:0] head;
  logic              dec_long;
  logic [OPC_W-1:0]  dec_opcode;
  logic [INST_W-1:0] dec_imm;

  assign bus.in_ready  = (state_q != OCC_FULL);
  assign bus.out_valid = (state_q != OCC_EMPTY);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;
  assign dbg_state     = state_q;
  assign bus.count     = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= OCC_EMPTY;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.flush) begin
      state_q  <= OCC_EMPTY;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) begin
        mem[wr_ptr_q] <= bus.in_inst;
        wr_ptr_q      <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q + CW'(push) - CW'(pop);
    case (state_q)
      OCC_EMPTY:   if (push) state_d = OCC_PARTIAL;
      OCC_PARTIAL: begin
        if (push && !pop && count_q == CW'(DEPTH - 1)) state_d = OCC_FULL;
        else if (pop && !push && count_q == CW'(1))    state_d = OCC_EMPTY;
      end
      OCC_FULL:    if (pop) state_d = OCC_PARTIAL;
      default:     state_d = OCC_EMPTY;
    endcase
  end

  assign head = mem[rd_ptr_q];

  ir_decode #(
    .INST_W   (INST_W),
    .SIGN_EXT (SIGN_EXT)
  ) u_decode (
    .inst     (head),
    .long_fmt (dec_long),
    .opcode   (dec_opcode),
    .imm      (dec_imm)
  );

  // Stale storage must never leak onto the decode outputs while empty.
  assign bus.out_inst   = bus.out_valid ? head       : '0;
  assign bus.out_long   = bus.out_valid && dec_long;
  assign bus.out_opcode = bus.out_valid ? dec_opcode : '0;
  assign bus.out_imm    = bus.out_valid ? dec_imm    : '0;

endmodule

// File: tb/tb_instr_prefetch_reg.sv
// Directed bench for instr_prefetch_reg: two instances (zero- and sign-extending) share stimulus.
module tb_instr_prefetch_reg;
  import ir_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_inst;
  logic        flush;
  logic        out_ready;
  occ_state_t  dbg_state0;
  occ_state_t  dbg_state1;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic        iv;
    logic [15:0] ii;
    logic        ordy;
    logic [1:0]  e_cnt;
    logic        e_ov;
    logic        e_ir;
    logic [15:0] e_inst;
  } vec_t;

  vec_t vecs [14];

  instr_prefetch_reg_if #(.INST_W(16), .DEPTH(2)) bus0 ();
  instr_prefetch_reg_if #(.INST_W(16), .DEPTH(2)) bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.in_inst   = in_inst;
  assign bus0.flush     = flush;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_inst   = in_inst;
  assign bus1.flush     = flush;
  assign bus1.out_ready = out_ready;

  instr_prefetch_reg #(.INST_W(16), .DEPTH(2), .SIGN_EXT(0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus0.slave),
    .dbg_state (dbg_state0)
  );

  instr_prefetch_reg #(.INST_W(16), .DEPTH(2), .SIGN_EXT(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus1.slave),
    .dbg_state (dbg_state1)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver helpers
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  initial begin
    // Directed table: inputs applied for one edge, expectations read after it.
    //            iv  inst      rdy  cnt  ov  ir  head
    vecs[0]  = '{1, 16'h1111, 0, 2'd1, 1, 1, 16'h1111};
    vecs[1]  = '{1, 16'h2222, 0, 2'd2, 1, 0, 16'h1111};
    vecs[2]  = '{1, 16'h3333, 0, 2'd2, 1, 0, 16'h1111};
    vecs[3]  = '{1, 16'h3333, 1, 2'd1, 1, 1, 16'h2222};
    vecs[4]  = '{1, 16'h3333, 0, 2'd2, 1, 0, 16'h2222};
    vecs[5]  = '{0, 16'h0000, 1, 2'd1, 1, 1, 16'h3333};
    vecs[6]  = '{1, 16'h4444, 0, 2'd2, 1, 0, 16'h3333};
    vecs[7]  = '{1, 16'h5555, 1, 2'd1, 1, 1, 16'h4444};
    vecs[8]  = '{1, 16'h5555, 0, 2'd2, 1, 0, 16'h4444};
    vecs[9]  = '{1, 16'h6666, 1, 2'd1, 1, 1, 16'h5555};
    vecs[10] = '{1, 16'h6666, 1, 2'd1, 1, 1, 16'h6666};
    vecs[11] = '{0, 16'h0000, 1, 2'd0, 0, 1, 16'h0000};
    vecs[12] = '{1, 16'h7777, 1, 2'd1, 1, 1, 16'h7777};
    vecs[13] = '{1, 16'h8888, 0, 2'd2, 1, 0, 16'h7777};

    rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; flush = 1'b0; out_ready = 1'b0;
    #2;
    check("reset_count",     32'(bus0.count),     32'd0);
    check("reset_out_valid", 32'(bus0.out_valid), 32'd0);
    check("reset_in_ready",  32'(bus0.in_ready),  32'd1);
    check("reset_state",     32'(dbg_state0),     32'(OCC_EMPTY));
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Long-format decode
    in_valid = 1'b1; in_inst = 16'hA123;
    cycle();
    in_valid = 1'b0;
    check("long_inst",   32'(bus0.out_inst),   32'h0000A123);
    check("long_fmt",    32'(bus0.out_long),   32'd1);
    check("long_opcode", 32'(bus0.out_opcode), 32'b10100);
    check("long_imm_z",  32'(bus0.out_imm),    32'h00000123);
    check("long_imm_s",  32'(bus1.out_imm),    32'h00000123);
    check("long_count",  32'(bus0.count),      32'd1);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    check("pop_count",   32'(bus0.count),      32'd0);
    check("empty_inst",  32'(bus0.out_inst),   32'd0);
    check("empty_long",  32'(bus0.out_long),   32'd0);
    check("empty_opc",   32'(bus0.out_opcode), 32'd0);
    check("empty_imm",   32'(bus0.out_imm),    32'd0);

    // Short-format decode, both extension modes
    in_valid = 1'b1; in_inst = 16'h7F85;
    cycle();
    in_valid = 1'b0;
    check("short_fmt",    32'(bus0.out_long),   32'd0);
    check("short_opcode", 32'(bus0.out_opcode), 32'b01111);
    check("short_imm_z",  32'(bus0.out_imm),    32'h00000785);
    check("short_imm_s",  32'(bus1.out_imm),    32'h0000FF85);
    check("short_opc_s",  32'(bus1.out_opcode), 32'b01111);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    check("short_pop", 32'(bus0.out_valid), 32'd0);

    // Fill, hold, wrap and simultaneous push+pop
    for (int i = 0; i < 14; i++) begin
      in_valid  = vecs[i].iv;
      in_inst   = vecs[i].ii;
      out_ready = vecs[i].ordy;
      cycle();
      check($sformatf("vec%0d_count", i),     32'(bus0.count),     32'(vecs[i].e_cnt));
      check($sformatf("vec%0d_out_valid", i), 32'(bus0.out_valid), 32'(vecs[i].e_ov));
      check($sformatf("vec%0d_in_ready", i),  32'(bus0.in_ready),  32'(vecs[i].e_ir));
      check($sformatf("vec%0d_head", i),      32'(bus0.out_inst),  32'(vecs[i].e_inst));
    end
    check("full_state", 32'(dbg_state0), 32'(OCC_FULL));

    // Flush at count 2 with push and pop requested
    in_valid = 1'b1; in_inst = 16'h9999; out_ready = 1'b1; flush = 1'b1;
    #1;
    check("flush_pre_in_ready",  32'(bus0.in_ready),  32'd0);
    check("flush_pre_out_valid", 32'(bus0.out_valid), 32'd1);
    cycle();
    check("flush_count",     32'(bus0.count),     32'd0);
    check("flush_out_valid", 32'(bus0.out_valid), 32'd0);
    check("flush_in_ready",  32'(bus0.in_ready),  32'd1);
    check("flush_state",     32'(dbg_state0),     32'(OCC_EMPTY));
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cycle();
    check("flush_discard", 32'(bus0.count), 32'd0);
    in_valid = 1'b1; in_inst = 16'hAAAA;
    cycle();
    check("post_flush_head", 32'(bus0.out_inst), 32'h0000AAAA);

    // Asynchronous reset with two words queued
    in_inst = 16'hBBBB;
    cycle();
    in_valid = 1'b0;
    check("pre_reset_count", 32'(bus0.count), 32'd2);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_count",     32'(bus0.count),     32'd0);
    check("async_out_valid", 32'(bus0.out_valid), 32'd0);
    check("async_in_ready",  32'(bus0.in_ready),  32'd1);
    check("async_imm",       32'(bus0.out_imm),   32'd0);
    check("async_inst",      32'(bus0.out_inst),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_inst = 16'hCCCC;
    cycle();
    in_valid = 1'b0;
    check("post_reset_head",  32'(bus0.out_inst), 32'h0000CCCC);
    check("post_reset_count", 32'(bus0.count),    32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
